// File: rtl/vga_pkg.sv
// Shared VGA raster timing defaults (SVGA 800x600, 1056x628 total) and total-length helpers.
package vga_pkg;

    localparam int unsigned SVGA_H_ACTIVE = 800;
    localparam int unsigned SVGA_H_FP     = 40;
    localparam int unsigned SVGA_H_SYNC   = 128;
    localparam int unsigned SVGA_H_BP     = 88;
    localparam int unsigned SVGA_V_ACTIVE = 600;
    localparam int unsigned SVGA_V_FP     = 1;
    localparam int unsigned SVGA_V_SYNC   = 4;
    localparam int unsigned SVGA_V_BP     = 23;

    localparam int unsigned H_COORD_W   = 11;
    localparam int unsigned V_COORD_W   = 10;
    localparam int unsigned FRAME_CNT_W = 16;

    localparam int unsigned H_TOTAL_MAX = 2048;
    localparam int unsigned V_TOTAL_MAX = 1024;

    function automatic int unsigned axis_total(input int unsigned active, input int unsigned fp,
                                               input int unsigned sync, input int unsigned bp);
        return active + fp + sync + bp;
    endfunction

    function automatic int unsigned h_total(input int unsigned active, input int unsigned fp,
                                            input int unsigned sync, input int unsigned bp);
        return axis_total(active, fp, sync, bp);
    endfunction

    function automatic int unsigned v_total(input int unsigned active, input int unsigned fp,
                                            input int unsigned sync, input int unsigned bp);
        return axis_total(active, fp, sync, bp);
    endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: wrapping position counter plus combinational sync/active decode of its count.
module vga_axis_counter
    import vga_pkg::*;
#(
    parameter int unsigned ACTIVE = SVGA_H_ACTIVE,
    parameter int unsigned FP     = SVGA_H_FP,
    parameter int unsigned SYNC   = SVGA_H_SYNC,
    parameter int unsigned BP     = SVGA_H_BP,
    parameter logic        POL    = 1'b1,
    parameter int unsigned W      = H_COORD_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         step,
    output logic         wrap,
    output logic [W-1:0] count,
    output logic         sync,
    output logic         active
);

    localparam int unsigned TOTAL      = axis_total(ACTIVE, FP, SYNC, BP);
    localparam int unsigned SYNC_START = ACTIVE + FP;
    localparam int unsigned SYNC_END   = ACTIVE + FP + SYNC;
    localparam logic [W-1:0] LAST      = W'(TOTAL - 1);

    logic in_sync;

    assign wrap = step && (count == LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (step) begin
            count <= wrap ? '0 : count + W'(1);
        end
    end

    // Compare at 32 bits so an axis whose region ends exactly at 2^W still decodes correctly.
    always_comb begin
        in_sync = (32'(count) >= SYNC_START) && (32'(count) < SYNC_END);
        active  = 32'(count) < ACTIVE;
        sync    = in_sync ? POL : ~POL;
    end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: free-running h/v counters decoded into registered coords, syncs and strobes.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int unsigned H_ACTIVE   = SVGA_H_ACTIVE,
    parameter int unsigned H_FP       = SVGA_H_FP,
    parameter int unsigned H_SYNC     = SVGA_H_SYNC,
    parameter int unsigned H_BP       = SVGA_H_BP,
    parameter int unsigned V_ACTIVE   = SVGA_V_ACTIVE,
    parameter int unsigned V_FP       = SVGA_V_FP,
    parameter int unsigned V_SYNC     = SVGA_V_SYNC,
    parameter int unsigned V_BP       = SVGA_V_BP,
    parameter logic        H_SYNC_POL = 1'b1,
    parameter logic        V_SYNC_POL = 1'b1
) (
    input  logic                   pixel_clk,
    input  logic                   rst,
    output logic [H_COORD_W-1:0]   h_coord,
    output logic [V_COORD_W-1:0]   v_coord,
    output logic                   hsync,
    output logic                   vsync,
    output logic                   display_on,
    output logic                   frame_start,
    output logic                   active_end,
    output logic [FRAME_CNT_W-1:0] frame_cnt
);

    localparam int unsigned H_TOTAL = h_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int unsigned V_TOTAL = v_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
    localparam logic [H_COORD_W-1:0] H_LAST_ACTIVE = H_COORD_W'(H_ACTIVE - 1);
    localparam logic [V_COORD_W-1:0] V_LAST_ACTIVE = V_COORD_W'(V_ACTIVE - 1);

    if (H_TOTAL > H_TOTAL_MAX) begin : g_h_total_chk
        $error("vga_timing_gen: H_TOTAL exceeds 2048");
    end
    if (V_TOTAL > V_TOTAL_MAX) begin : g_v_total_chk
        $error("vga_timing_gen: V_TOTAL exceeds 1024");
    end

    logic [H_COORD_W-1:0] h_cnt;
    logic [V_COORD_W-1:0] v_cnt;
    logic                 h_wrap;
    logic                 v_wrap_unused;
    logic                 h_sync;
    logic                 v_sync;
    logic                 h_active;
    logic                 v_active;

    vga_axis_counter #(
        .ACTIVE (H_ACTIVE),
        .FP     (H_FP),
        .SYNC   (H_SYNC),
        .BP     (H_BP),
        .POL    (H_SYNC_POL),
        .W      (H_COORD_W)
    ) u_h_axis (
        .clk    (pixel_clk),
        .rst    (rst),
        .step   (1'b1),
        .wrap   (h_wrap),
        .count  (h_cnt),
        .sync   (h_sync),
        .active (h_active)
    );

    // Vertical axis advances once per line, so vsync edges land on h=0.
    vga_axis_counter #(
        .ACTIVE (V_ACTIVE),
        .FP     (V_FP),
        .SYNC   (V_SYNC),
        .BP     (V_BP),
        .POL    (V_SYNC_POL),
        .W      (V_COORD_W)
    ) u_v_axis (
        .clk    (pixel_clk),
        .rst    (rst),
        .step   (h_wrap),
        .wrap   (v_wrap_unused),
        .count  (v_cnt),
        .sync   (v_sync),
        .active (v_active)
    );

    // Every output is sampled from the same h_cnt/v_cnt pair; frame_cnt steps the cycle after active_end.
    always_ff @(posedge pixel_clk) begin
        if (rst) begin
            h_coord     <= '0;
            v_coord     <= '0;
            hsync       <= ~H_SYNC_POL;
            vsync       <= ~V_SYNC_POL;
            display_on  <= 1'b0;
            frame_start <= 1'b0;
            active_end  <= 1'b0;
            frame_cnt   <= '0;
        end else begin
            h_coord     <= h_cnt;
            v_coord     <= v_cnt;
            hsync       <= h_sync;
            vsync       <= v_sync;
            display_on  <= h_active && v_active;
            frame_start <= (h_cnt == '0) && (v_cnt == '0);
            active_end  <= (h_cnt == H_LAST_ACTIVE) && (v_cnt == V_LAST_ACTIVE);
            frame_cnt   <= frame_cnt + FRAME_CNT_W'(active_end);
        end
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: default SVGA and a tiny override instance, both checked every cycle against a raster model.
module tb_vga_timing_gen;

    typedef struct {
        int   h;
        int   v;
        logic hs;
        logic vs;
        logic de;
        logic fs;
        logic ae;
        int   fc;
    } exp_t;

    typedef struct {
        int   ha, hf, hs, hb;
        int   va, vf, vs, vb;
        logic hp, vp;
    } cfg_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_d = 1'b1;
    logic rst_s = 1'b1;

    logic [10:0] h_d, h_s;
    logic [9:0]  v_d, v_s;
    logic        hs_d, hs_s, vs_d, vs_s, de_d, de_s, fs_d, fs_s, ae_d, ae_s;
    logic [15:0] fc_d, fc_s;

    vga_timing_gen dut_d (
        .pixel_clk   (clk),
        .rst         (rst_d),
        .h_coord     (h_d),
        .v_coord     (v_d),
        .hsync       (hs_d),
        .vsync       (vs_d),
        .display_on  (de_d),
        .frame_start (fs_d),
        .active_end  (ae_d),
        .frame_cnt   (fc_d)
    );

    vga_timing_gen #(
        .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
        .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .H_SYNC_POL(1'b0), .V_SYNC_POL(1'b1)
    ) dut_s (
        .pixel_clk   (clk),
        .rst         (rst_s),
        .h_coord     (h_s),
        .v_coord     (v_s),
        .hsync       (hs_s),
        .vsync       (vs_s),
        .display_on  (de_s),
        .frame_start (fs_s),
        .active_end  (ae_s),
        .frame_cnt   (fc_s)
    );

    int total = 0;
    int bad = 0;
    int pos_d = -1;
    int pos_s = -1;
    int fc_off = 0;
    cfg_t cfg_d, cfg_s;

    // Output index since reset release; -1 means outputs hold reset values.
    always @(posedge clk) begin
        pos_d <= rst_d ? -1 : pos_d + 1;
        pos_s <= rst_s ? -1 : pos_s + 1;
    end

    function automatic exp_t model(input cfg_t c, input int pos);
        exp_t e;
        int ht, vt, ft, ae_pos;
        ht = c.ha + c.hf + c.hs + c.hb;
        vt = c.va + c.vf + c.vs + c.vb;
        ft = ht * vt;
        ae_pos = (c.va - 1) * ht + c.ha - 1;
        e = '{default: 0};
        e.hs = ~c.hp;
        e.vs = ~c.vp;
        if (pos >= 0) begin
            e.h  = pos % ht;
            e.v  = (pos / ht) % vt;
            e.hs = (e.h >= c.ha + c.hf && e.h < c.ha + c.hf + c.hs) ? c.hp : ~c.hp;
            e.vs = (e.v >= c.va + c.vf && e.v < c.va + c.vf + c.vs) ? c.vp : ~c.vp;
            e.de = (e.h < c.ha) && (e.v < c.va);
            e.fs = (pos % ft) == 0;
            e.ae = (pos % ft) == ae_pos;
            e.fc = (pos > ae_pos) ? ((pos - ae_pos - 1) / ft + 1) % 65536 : 0;
        end
        return e;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_d();
        exp_t e;
        e = model(cfg_d, pos_d);
        chk("d_h_coord", 32'(h_d), 32'(e.h));
        chk("d_v_coord", 32'(v_d), 32'(e.v));
        chk("d_hsync", 32'(hs_d), 32'(e.hs));
        chk("d_vsync", 32'(vs_d), 32'(e.vs));
        chk("d_display_on", 32'(de_d), 32'(e.de));
        chk("d_frame_start", 32'(fs_d), 32'(e.fs));
        chk("d_active_end", 32'(ae_d), 32'(e.ae));
        chk("d_frame_cnt", 32'(fc_d), 32'(e.fc));
    endtask

    task automatic chk_s();
        exp_t e;
        e = model(cfg_s, pos_s);
        chk("s_h_coord", 32'(h_s), 32'(e.h));
        chk("s_v_coord", 32'(v_s), 32'(e.v));
        chk("s_hsync", 32'(hs_s), 32'(e.hs));
        chk("s_vsync", 32'(vs_s), 32'(e.vs));
        chk("s_display_on", 32'(de_s), 32'(e.de));
        chk("s_frame_start", 32'(fs_s), 32'(e.fs));
        chk("s_active_end", 32'(ae_s), 32'(e.ae));
        chk("s_frame_cnt", 32'(fc_s), 32'((e.fc + fc_off) % 65536));
    endtask

    task automatic tick();
        @(negedge clk);
        chk_d();
        chk_s();
    endtask

    task automatic wait_s_phase(input int phase, input string tag);
        int n = 0;
        while ((pos_s < 0 || (pos_s % 48) != phase) && n < 200) begin
            tick();
            n++;
        end
        chk(tag, 32'(n < 200), 32'd1);
    endtask

    task automatic wait_d_pos(input int target);
        int n = 0;
        while (pos_d != target && n < 5000) begin
            tick();
            n++;
        end
        chk("wait_d_pos", 32'(pos_d == target), 32'd1);
    endtask

    initial begin
        int de_cnt, hs_cnt, hs_first, lo_cnt, lo_sum, per, fc0;
        cfg_d = '{800, 40, 128, 88, 600, 1, 4, 23, 1'b1, 1'b1};
        cfg_s = '{4, 1, 2, 1, 3, 1, 1, 1, 1'b0, 1'b1};

        // Reset, small instance released after a random extra delay.
        tick();
        tick();
        chk("rst_hsync_d", 32'(hs_d), 32'd0);
        chk("rst_hsync_s", 32'(hs_s), 32'd1);
        repeat ($urandom_range(0, 3)) tick();
        rst_s = 1'b0;
        tick();
        tick();

        // Default instance: first cycle after release still shows reset values.
        rst_d = 1'b0;
        chk("rel_h_d", 32'(h_d), 32'd0);
        chk("rel_fs_d", 32'(fs_d), 32'd0);
        chk("rel_de_d", 32'(de_d), 32'd0);
        tick();
        chk("first_fs_d", 32'(fs_d), 32'd1);
        chk("first_de_d", 32'(de_d), 32'd1);
        chk("first_hsync_d", 32'(hs_d), 32'd0);
        chk("first_vsync_d", 32'(vs_d), 32'd0);

        // One full default line starting at pos 0.
        de_cnt = 32'(de_d);
        hs_cnt = 32'(hs_d);
        hs_first = -1;
        for (int i = 1; i < 1056; i++) begin
            tick();
            de_cnt += 32'(de_d);
            hs_cnt += 32'(hs_d);
            if (hs_d && hs_first < 0) hs_first = 32'(h_d);
        end
        chk("line_de_cnt", 32'(de_cnt), 32'd800);
        chk("line_hs_cnt", 32'(hs_cnt), 32'd128);
        chk("line_hs_first", 32'(hs_first), 32'd840);
        tick();
        chk("line_wrap_h", 32'(h_d), 32'd0);
        chk("line_wrap_v", 32'(v_d), 32'd1);

        // Small instance: hsync low at h=5,6; line period 8; frame period 48.
        wait_s_phase(0, "wait_s_frame0");
        lo_cnt = 0;
        lo_sum = 0;
        for (int i = 0; i < 8; i++) begin
            if (!hs_s) begin
                lo_cnt++;
                lo_sum += 32'(h_s);
            end
            tick();
        end
        chk("s_hs_lo_cnt", 32'(lo_cnt), 32'd2);
        chk("s_hs_lo_sum", 32'(lo_sum), 32'd11);
        chk("s_line_v", 32'(v_s), 32'd1);
        chk("s_line_h", 32'(h_s), 32'd0);
        wait_s_phase(0, "wait_s_frame1");
        fc0 = 32'(fc_s);
        per = 0;
        do begin
            tick();
            per++;
        end while (!fs_s && per < 200);
        chk("s_frame_period", 32'(per), 32'd48);
        repeat (96) tick();
        chk("s_fc_3frames", 32'((32'(fc_s) - fc0) & 16'hFFFF), 32'd3);

        // Preload frame_cnt near wrap, then watch it roll over at the next active_end.
        wait_s_phase(0, "wait_s_force");
        fc_off = 65535 - model(cfg_s, pos_s).fc;
        force dut_s.frame_cnt = 16'hFFFF;
        tick();
        release dut_s.frame_cnt;
        tick();
        chk("s_fc_preload", 32'(fc_s), 32'hFFFF);
        wait_s_phase(20, "wait_s_wrap");
        chk("s_fc_wrap", 32'(fc_s), 32'd0);

        // Mid-frame reset on the default instance at (412,2).
        wait_d_pos(2 * 1056 + 412);
        chk("mid_h_d", 32'(h_d), 32'd412);
        rst_d = 1'b1;
        tick();
        chk("mid_rst_ae_d", 32'(ae_d), 32'd0);
        chk("mid_rst_h_d", 32'(h_d), 32'd0);
        tick();
        rst_d = 1'b0;
        tick();
        chk("restart_fs_d", 32'(fs_d), 32'd1);
        chk("restart_fc_d", 32'(fc_d), 32'd0);

        // Reset the small instance one cycle before active_end: no strobe may escape.
        wait_s_phase(18, "wait_s_pre_ae");
        rst_s = 1'b1;
        fc_off = 0;
        tick();
        chk("s_pre_ae_rst", 32'(ae_s), 32'd0);
        tick();
        rst_s = 1'b0;

        // Random mid-frame resets of random length on the small instance.
        for (int k = 0; k < 6; k++) begin
            repeat ($urandom_range(1, 120)) tick();
            rst_s = 1'b1;
            fc_off = 0;
            repeat ($urandom_range(1, 3)) tick();
            rst_s = 1'b0;
        end
        repeat (150) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
